// File: rtl/aib_sr_frame_tx_if.sv
// Parallel word handshake between the status logic and the sideband frame transmitter.
interface aib_sr_frame_tx_if #(
  parameter int unsigned WIDTH = 81
) ();
  logic [WIDTH-1:0] sb_data;
  logic             sb_valid;
  logic             sb_ready;

  modport master (output sb_data, output sb_valid, input sb_ready);
  modport slave  (input sb_data, input sb_valid, output sb_ready);
endinterface

// File: rtl/aib_sr_frame_tx.sv
// Sideband shift-register frame transmitter: sends a WIDTH-bit word MSB first,
// then a load strobe, repeating frames back to back (or with a fixed idle gap).
module aib_sr_frame_tx #(
  parameter int unsigned      WIDTH      = 81,
  parameter int unsigned      LOAD_CYC   = 1,
  parameter int unsigned      GAP_CYC    = 0,
  parameter logic [WIDTH-1:0] RESET_WORD = '0,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             osc_clk,
  input  logic             sr_rst,
  input  logic             sr_en,
  aib_sr_frame_tx_if.slave sb,
  output logic             sr_dout,
  output logic             sr_load,
  output logic             sr_clk_en,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned MAX_LG  = (LOAD_CYC > GAP_CYC) ? LOAD_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (WIDTH > MAX_LG) ? WIDTH : MAX_LG;
  localparam int unsigned PH_W    = $clog2(MAX_CYC + 1);

  localparam logic [PH_W-1:0] LAST_BIT  = PH_W'(WIDTH - 1);
  localparam logic [PH_W-1:0] LAST_LOAD = PH_W'(LOAD_CYC - 1);
  localparam logic [PH_W-1:0] LAST_GAP  = (GAP_CYC == 0) ? '0 : PH_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, GAP} state_t;

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] held_word;

  logic             last_load_c;
  logic             last_gap_c;
  logic             frame_end_c;
  logic             launch_c;
  logic [PH_W-1:0]  next_phase_c;
  logic [WIDTH-1:0] word_c;

  // Frame boundary detection: a new frame may start from IDLE or on the final cycle of a frame.
  assign last_load_c  = (state == LOAD) && (phase == LAST_LOAD);
  assign last_gap_c   = (state == GAP) && (phase == LAST_GAP);
  assign frame_end_c  = (GAP_CYC == 0) ? last_load_c : last_gap_c;
  assign launch_c     = sr_en && ((state == IDLE) || frame_end_c);
  assign sb.sb_ready  = launch_c;
  assign next_phase_c = phase + 1'b1;
  assign word_c       = sb.sb_valid ? sb.sb_data : held_word;

  // Frame sequencer with registered serial outputs.
  always_ff @(posedge osc_clk) begin
    if (sr_rst) begin
      state      <= IDLE;
      phase      <= '0;
      shreg      <= '0;
      held_word  <= RESET_WORD;
      sr_dout    <= 1'b0;
      sr_load    <= 1'b0;
      sr_clk_en  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      sr_dout    <= 1'b0;
      sr_load    <= 1'b0;
      sr_clk_en  <= 1'b0;
      frame_done <= 1'b0;
      if (launch_c) begin
        // Fresh word when offered, otherwise resend the last word held.
        state     <= SHIFT;
        phase     <= '0;
        shreg     <= {word_c[WIDTH-2:0], 1'b0};
        sr_dout   <= word_c[WIDTH-1];
        sr_clk_en <= 1'b1;
        busy      <= 1'b1;
        if (sb.sb_valid) begin
          held_word <= sb.sb_data;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          SHIFT: begin
            busy      <= 1'b1;
            sr_clk_en <= 1'b1;
            if (phase == LAST_BIT) begin
              state   <= LOAD;
              phase   <= '0;
              sr_load <= 1'b1;
              if (LOAD_CYC == 1) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
              end
            end else begin
              phase   <= next_phase_c;
              sr_dout <= shreg[WIDTH-1];
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
            end
          end
          LOAD: begin
            if (phase == LAST_LOAD) begin
              phase <= '0;
              if (GAP_CYC == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
                busy  <= 1'b1;
              end
            end else begin
              phase     <= next_phase_c;
              busy      <= 1'b1;
              sr_load   <= 1'b1;
              sr_clk_en <= 1'b1;
              if (next_phase_c == LAST_LOAD) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
              end
            end
          end
          GAP: begin
            if (phase == LAST_GAP) begin
              state <= IDLE;
              phase <= '0;
              busy  <= 1'b0;
            end else begin
              phase <= next_phase_c;
              busy  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            phase <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aib_sr_frame_tx.sv
// Bench for the sideband frame transmitter: two configurations (81/1/0 and 73/2/3),
// a frame-level reference model feeding a scoreboard, and a cycle monitor.
module tb_aib_sr_frame_tx;

  localparam int WID [2] = '{81, 73};
  localparam int LCY [2] = '{1, 2};
  localparam int GCY [2] = '{0, 3};
  localparam int CWD [2] = '{16, 4};
  localparam logic [72:0] RW1 = 73'h1_2345_6789_ABCD_EF01_23;

  typedef struct {
    logic [80:0] word;
    int          f;
  } frame_t;

  logic        osc_clk;
  logic [1:0]  rst;
  logic [1:0]  en;
  logic [1:0]  valid;
  logic [80:0] data [2];
  int          cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  // reference model state (driver side)
  bit          running [2];
  int          last_f [2];
  logic [80:0] held [2];
  frame_t      q0[$];
  frame_t      q1[$];

  // monitor state
  bit          cur_v [2];
  logic [80:0] cur_w [2];
  int          cur_f [2];
  int          mc [2];

  logic        d0_dout, d0_load, d0_clk_en, d0_done, d0_busy;
  logic        d1_dout, d1_load, d1_clk_en, d1_done, d1_busy;
  logic [15:0] fc0;
  logic [3:0]  fc1;

  aib_sr_frame_tx_if #(.WIDTH(81)) if0 ();
  aib_sr_frame_tx_if #(.WIDTH(73)) if1 ();

  assign if0.sb_data  = data[0];
  assign if0.sb_valid = valid[0];
  assign if1.sb_data  = data[1][72:0];
  assign if1.sb_valid = valid[1];

  aib_sr_frame_tx #(.WIDTH(81), .LOAD_CYC(1), .GAP_CYC(0), .RESET_WORD('0), .CNT_W(16)) u_dut0 (
    .osc_clk(osc_clk), .sr_rst(rst[0]), .sr_en(en[0]), .sb(if0),
    .sr_dout(d0_dout), .sr_load(d0_load), .sr_clk_en(d0_clk_en),
    .frame_done(d0_done), .busy(d0_busy), .frame_cnt(fc0)
  );

  aib_sr_frame_tx #(.WIDTH(73), .LOAD_CYC(2), .GAP_CYC(3), .RESET_WORD(RW1), .CNT_W(4)) u_dut1 (
    .osc_clk(osc_clk), .sr_rst(rst[1]), .sr_en(en[1]), .sb(if1),
    .sr_dout(d1_dout), .sr_load(d1_load), .sr_clk_en(d1_clk_en),
    .frame_done(d1_done), .busy(d1_busy), .frame_cnt(fc1)
  );

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  always @(posedge osc_clk) cyc <= cyc + 1;

  function automatic int per(int k);
    return WID[k] + LCY[k] + GCY[k];
  endfunction

  function automatic logic [80:0] mask(int k);
    logic [80:0] one;
    one = 81'd1;
    return (one << WID[k]) - 81'd1;
  endfunction

  function automatic logic [80:0] rnd();
    return 81'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic chk(string name, int k, logic [80:0] act, logic [80:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
    end
  endtask

  // Frame-level model: decides boundaries from sr_en and the frame period, queues frames.
  task automatic model_cycle(int k, logic rdy);
    bit          bnd;
    frame_t      fr;
    logic [80:0] w;
    bnd = !rst[k] && en[k] && (!running[k] || (cyc == last_f[k] + per(k)));
    if (cyc > 0) chk("sb_ready", k, 81'(rdy), 81'(bnd));
    if (rst[k]) begin
      running[k] = 0;
      held[k]    = (k == 0) ? 81'd0 : 81'(RW1);
    end else if (bnd) begin
      w = valid[k] ? (data[k] & mask(k)) : held[k];
      if (valid[k]) held[k] = w;
      fr.word = w;
      fr.f    = cyc;
      if (k == 0) q0.push_back(fr); else q1.push_back(fr);
      last_f[k]  = cyc;
      running[k] = 1;
    end else if (running[k] && (cyc == last_f[k] + per(k))) begin
      running[k] = 0;
    end
  endtask

  task automatic tick();
    logic [1:0] rdy;
    #1;
    rdy = {if1.sb_ready, if0.sb_ready};
    for (int k = 0; k < 2; k++) model_cycle(k, rdy[k]);
    @(posedge osc_clk);
    #1;
  endtask

  // Monitor: picks up each queued frame as it appears and checks the serial waveform.
  task automatic mon(int k, logic [4:0] obs, logic [31:0] fc);
    frame_t     fr;
    int         d;
    logic [4:0] exp;
    bit         have;
    have = (k == 0) ? (q0.size() > 0 && q0[0].f == cyc - 1) : (q1.size() > 0 && q1[0].f == cyc - 1);
    if (have) begin
      fr = (k == 0) ? q0.pop_front() : q1.pop_front();
      cur_v[k] = 1;
      cur_w[k] = fr.word;
      cur_f[k] = fr.f;
    end
    if (cur_v[k] && (cyc - cur_f[k] > per(k))) cur_v[k] = 0;
    exp = 5'b00000;
    if (cur_v[k]) begin
      d = cyc - cur_f[k];
      if (d >= 1 && d <= WID[k])
        exp = {cur_w[k][WID[k] - d], 1'b0, 1'b1, 1'b0, 1'b1};
      else if (d <= WID[k] + LCY[k])
        exp = {1'b0, 1'b1, 1'b1, (d == WID[k] + LCY[k]), 1'b1};
      else
        exp = 5'b00001;
    end
    if (exp[1]) mc[k] = (mc[k] + 1) % (1 << CWD[k]);
    chk("dout_load_clken_done_busy", k, 81'(obs), 81'(exp));
    chk("frame_cnt", k, 81'(fc), 81'(mc[k]));
    if (rst[k]) begin
      cur_v[k] = 0;
      mc[k]    = 0;
    end
  endtask

  always @(negedge osc_clk) begin
    if (cyc > 0) begin
      mon(0, {d0_dout, d0_load, d0_clk_en, d0_done, d0_busy}, 32'(fc0));
      mon(1, {d1_dout, d1_load, d1_clk_en, d1_done, d1_busy}, 32'(fc1));
    end
  end

  initial begin
    logic [1:0] done;
    for (int k = 0; k < 2; k++) begin
      running[k] = 0; last_f[k] = 0; held[k] = '0;
      cur_v[k] = 0; cur_w[k] = '0; cur_f[k] = 0; mc[k] = 0;
    end
    en = 2'b00; valid = 2'b00; rst = 2'b11;
    data[0] = '0; data[1] = '0;
    repeat (3) tick();
    rst = 2'b00;
    repeat (2) tick();

    // single-bit-ends pattern on dut0, then resend the held word for 3 more frames
    en = 2'b11; valid = 2'b11;
    data[0] = 81'h1_0000_0000_0000_0000_0001;
    data[1] = rnd();
    tick();
    valid = 2'b00;
    data[0] = rnd(); data[1] = rnd();
    repeat (4 * 82) tick();

    // random offers and data churn while frames run back to back
    repeat (1400) begin
      for (int k = 0; k < 2; k++) begin
        valid[k] = ($urandom_range(0, 3) == 0);
        data[k]  = rnd();
      end
      tick();
    end

    // drop sr_en at bit 40 of a frame; the frame must finish and no new one start
    valid = 2'b00;
    done  = 2'b00;
    for (int i = 0; i < 400 && done != 2'b11; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!done[k] && running[k] && (cyc - last_f[k] == 40)) begin
          en[k]   = 1'b0;
          done[k] = 1'b1;
        end
      end
      tick();
    end
    chk("en_drop_reached", 0, 81'(done), 81'(2'b11));
    repeat (200) tick();

    // reset at bit 20, then resend with sb_valid=0 so the reset word goes out
    en = 2'b11; valid = 2'b11;
    data[0] = rnd(); data[1] = rnd();
    tick();
    valid = 2'b00;
    done  = 2'b00;
    for (int i = 0; i < 400 && done != 2'b11; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          rst[k]  = 1'b0;
          en[k]   = 1'b1;
          done[k] = 1'b1;
        end else if (!done[k] && running[k] && (cyc - last_f[k] == 20)) begin
          rst[k] = 1'b1;
          en[k]  = 1'b0;
        end
      end
      tick();
    end
    chk("reset_reached", 1, 81'(done), 81'(2'b11));
    repeat (200) tick();
    en = 2'b00;
    repeat (200) tick();

    chk("queue0_drained", 0, 81'(q0.size()), 81'd0);
    chk("queue1_drained", 1, 81'(q1.size()), 81'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
